// File: rtl/radiant_wb_cmd_master.sv
// radiant_wb_cmd_master: single-command Wishbone classic initiator with ack/err/retry/timeout status.
// Reset asserts asynchronously and releases synchronously through a two-flop stage.
module radiant_wb_cmd_master #(
    parameter int ADR_W       = 9,
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    input  logic [3:0]       cmd_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic [1:0]       rsp_status_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [31:0]      wb_dat_o,
    output logic [3:0]       wb_sel_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_RTY = 2'b11;

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    logic [1:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [3:0]       rty_q, rty_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      rdat_q, rdat_d;
    logic [1:0]       st_q, st_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        rty_d   = rty_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
        st_d    = st_q;
        case (state_q)
            S_IDLE: if (cmd_valid_i) begin
                state_d = S_BUS;
                we_d    = cmd_we_i;
                adr_d   = cmd_adr_i & ~ADR_W'(3);
                dat_d   = cmd_dat_i;
                sel_d   = cmd_sel_i;
                tmo_d   = '0;
                rty_d   = '0;
            end
            S_BUS: begin
                // Priority ack > err > rty > timeout; responses outside BUS never reach here.
                if (wb_ack_i) begin
                    rdat_d  = we_q ? 32'd0 : wb_dat_i;
                    st_d    = ST_OK;
                    state_d = S_RESP;
                end else if (wb_err_i) begin
                    rdat_d  = '0;
                    st_d    = ST_ERR;
                    state_d = S_RESP;
                end else if (wb_rty_i) begin
                    if (rty_q == 4'(MAX_RETRY)) begin
                        rdat_d  = '0;
                        st_d    = ST_RTY;
                        state_d = S_RESP;
                    end else begin
                        rty_d   = rty_q + 4'd1;
                        state_d = S_GAP;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    rdat_d  = '0;
                    st_d    = ST_TMO;
                    state_d = S_RESP;
                end else begin
                    tmo_d = (&tmo_q) ? tmo_q : tmo_q + TMO_W'(1);
                end
            end
            S_GAP: begin
                tmo_d   = '0;
                state_d = S_BUS;
            end
            default: state_d = rsp_ready_i ? S_IDLE : S_RESP;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            rty_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdat_q  <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            rty_q   <= rty_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdat_q  <= rdat_d;
            st_q    <= st_d;
        end
    end

    // Strobes come straight from the state register so reset drops them without a clock.
    assign wb_cyc_o     = state_q == S_BUS;
    assign wb_stb_o     = state_q == S_BUS;
    assign cmd_ready_o  = state_q == S_IDLE;
    assign rsp_valid_o  = state_q == S_RESP;
    assign wb_we_o      = we_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign rsp_dat_o    = rdat_q;
    assign rsp_status_o = st_q;
endmodule

// File: tb/tb_radiant_wb_cmd_master.sv
// tb_radiant_wb_cmd_master: directed bench for the WB command master.
// Uses TIMEOUT_CYC=16 and MAX_RETRY=3; the slave is driven step by step from the sequence below.
module tb_radiant_wb_cmd_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [8:0]  cmd_adr = '0, wb_adr;
    logic [31:0] cmd_dat = '0, rsp_dat, wb_dat_o, wb_dat_i = '0;
    logic [3:0]  cmd_sel = '0, wb_sel;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [1:0]  rsp_status;
    logic        wb_cyc, wb_stb, wb_we;
    logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;
    int          checks = 0, errors = 0, c;

    radiant_wb_cmd_master #(.ADR_W(9), .TIMEOUT_CYC(16), .MAX_RETRY(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
        .rsp_status_o(rsp_status),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [8:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        chk("send_ready", 32'(cmd_ready), 32'd1);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("send_stb", 32'(wb_stb), 32'd1);
    endtask

    // Counts stb-high cycles; drives the given response on stb cycle n (n=0 never responds).
    task automatic attempt(input int n, input logic a, input logic e, input logic r, output int cnt);
        cnt = 0;
        while (wb_stb === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == n) {wb_ack, wb_err, wb_rty} = {a, e, r};
            tick();
            {wb_ack, wb_err, wb_rty} = 3'b000;
        end
    endtask

    task automatic gap_check();
        chk("gap_stb", 32'(wb_stb), 32'd0);
        chk("gap_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("gap_back", 32'(wb_stb), 32'd1);
    endtask

    task automatic expect_rsp(input string tag, input logic [1:0] st, input logic [31:0] dat);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_cyc"}, 32'(wb_cyc), 32'd0);
        chk({tag, "_noready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_status"}, 32'(rsp_status), 32'(st));
        chk({tag, "_dat"}, rsp_dat, dat);
        tick();
        chk({tag, "_hold"}, 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #3;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_stb", 32'(wb_stb), 32'd0);
        chk("rst_adr", 32'(wb_adr), 32'd0);
        chk("rst_dat", rsp_dat, 32'd0);
        #14 rst_n = 1'b1;
        repeat (3) tick();

        // write, ack on third stb cycle
        wb_dat_i = 32'hDEADBEEF;
        send(1'b1, 9'h000, 32'h00060007, 4'hF);
        chk("w_we", 32'(wb_we), 32'd1);
        chk("w_dat", wb_dat_o, 32'h00060007);
        chk("w_sel", 32'(wb_sel), 32'hF);
        attempt(3, 1'b1, 1'b0, 1'b0, c);
        chk("w_stbcnt", 32'(c), 32'd3);
        expect_rsp("w", 2'b00, 32'd0);

        // ack outside BUS is ignored
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("idle_ack_rsp", 32'(rsp_valid), 32'd0);
        chk("idle_ack_stb", 32'(wb_stb), 32'd0);

        // zero-wait read, low address bits dropped
        wb_dat_i = 32'h00FFFFFF;
        send(1'b0, 9'h00B, 32'h11111111, 4'h3);
        chk("r_adr", 32'(wb_adr), 32'h008);
        chk("r_we", 32'(wb_we), 32'd0);
        chk("r_sel", 32'(wb_sel), 32'h3);
        chk("r_early", 32'(rsp_valid), 32'd0);
        attempt(1, 1'b1, 1'b0, 1'b0, c);
        chk("r_stbcnt", 32'(c), 32'd1);
        expect_rsp("r", 2'b00, 32'h00FFFFFF);

        // timeout on a silent slave, then a normal write
        send(1'b0, 9'h010, 32'd0, 4'hF);
        attempt(0, 1'b0, 1'b0, 1'b0, c);
        chk("tmo_stbcnt", 32'(c), 32'd16);
        expect_rsp("tmo", 2'b10, 32'd0);
        send(1'b1, 9'h004, 32'hCAFE0001, 4'h1);
        attempt(2, 1'b1, 1'b0, 1'b0, c);
        chk("post_tmo_cnt", 32'(c), 32'd2);
        expect_rsp("post_tmo", 2'b00, 32'd0);

        // retry on every attempt: four bursts
        send(1'b1, 9'h020, 32'hA5A5A5A5, 4'hC);
        for (int i = 0; i < 4; i++) begin
            attempt(1, 1'b0, 1'b0, 1'b1, c);
            chk("rty_burst", 32'(c), 32'd1);
            if (i < 3) gap_check();
        end
        expect_rsp("rty_ex", 2'b11, 32'd0);

        // retry twice then ack
        send(1'b0, 9'h024, 32'd0, 4'hF);
        for (int i = 0; i < 2; i++) begin
            attempt(1, 1'b0, 1'b0, 1'b1, c);
            gap_check();
            chk("rty2_adr", 32'(wb_adr), 32'h024);
        end
        wb_dat_i = 32'h0BADF00D;
        attempt(2, 1'b1, 1'b0, 1'b0, c);
        chk("rty2_cnt", 32'(c), 32'd2);
        expect_rsp("rty2", 2'b00, 32'h0BADF00D);

        // ack and err together, then err alone
        wb_dat_i = 32'h12345678;
        send(1'b0, 9'h030, 32'd0, 4'hF);
        attempt(1, 1'b1, 1'b1, 1'b1, c);
        expect_rsp("ackerr", 2'b00, 32'h12345678);
        send(1'b0, 9'h030, 32'd0, 4'hF);
        attempt(1, 1'b0, 1'b1, 1'b1, c);
        expect_rsp("err", 2'b01, 32'd0);

        // reset mid-BUS
        send(1'b1, 9'h040, 32'h55AA55AA, 4'hF);
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", 32'(wb_cyc), 32'd0);
        chk("arst_stb", 32'(wb_stb), 32'd0);
        chk("arst_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        chk("arst_rsp2", 32'(rsp_valid), 32'd0);
        #2 rst_n = 1'b1;
        repeat (3) tick();
        chk("arst_rsp3", 32'(rsp_valid), 32'd0);
        send(1'b1, 9'h044, 32'h00000042, 4'hF);
        attempt(1, 1'b1, 1'b0, 1'b0, c);
        expect_rsp("post_rst", 2'b00, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
